led_mode_ctrl: RTL and testbench

Controller that sequences the 8-LED output bank of the board-level blink designs. It debounces the user push button, steps through four display modes on each press, and generates the step rate from a prescaler. It owns the `led` bus directly and sits between the top-level pins (`clk`, `rst`, `push_button`) and the LED outputs.

---
 rtl/led_mode_ctrl.sv | 133 +++++++++++++
 tb/tb_led_mode_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// Push-button mode selector for the 8-LED bank: synchronizes and debounces the button,
// cycles BLINK/SHIFT/PINGPONG/COUNT on each press and steps the pattern from a prescaler.
module led_mode_ctrl #(
  parameter int STEP_DIV        = 2_500_000,
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_button,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       step_tick
);

  localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_BLINK    = 2'd0,
    MODE_SHIFT    = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_COUNT    = 2'd3
  } mode_e;

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_dbCount;
  logic          r_dbLevel;
  logic          r_dbLevelPrev;
  logic [PW-1:0] r_presc;
  mode_e         r_state;
  logic [7:0]    r_led;
  logic          r_dirRight;

  logic          w_press;
  logic          w_prescTerm;
  mode_e         w_stateNext;
  logic [7:0]    w_ledNext;
  logic          w_dirNext;
  logic [PW-1:0] w_prescNext;

  // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES, so the
  // counter itself never needs to hold that value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_dbCount     <= '0;
      r_dbLevel     <= 1'b0;
      r_dbLevelPrev <= 1'b0;
    end else begin
      r_sync1       <= push_button;
      r_sync2       <= r_sync1;
      r_dbLevelPrev <= r_dbLevel;
      if (r_sync2 == r_dbLevel) begin
        r_dbCount <= '0;
      end else if (r_dbCount == DB_LAST) begin
        r_dbCount <= '0;
        r_dbLevel <= r_sync2;
      end else begin
        r_dbCount <= r_dbCount + 1'b1;
      end
    end
  end

  assign w_press     = r_dbLevel & ~r_dbLevelPrev;
  assign w_prescTerm = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= MODE_BLINK;
      r_led      <= 8'h00;
      r_dirRight <= 1'b0;
      r_presc    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_led      <= w_ledNext;
      r_dirRight <= w_dirNext;
      r_presc    <= w_prescNext;
    end
  end

  // A press outranks a coinciding terminal count: the step is dropped and the prescaler restarts.
  always_comb begin
    w_stateNext = r_state;
    w_ledNext   = r_led;
    w_dirNext   = r_dirRight;
    w_prescNext = w_prescTerm ? '0 : r_presc + 1'b1;
    if (w_press) begin
      w_prescNext = '0;
      w_dirNext   = 1'b0;
      case (r_state)
        MODE_BLINK: begin
          w_stateNext = MODE_SHIFT;
          w_ledNext   = 8'h01;
        end
        MODE_SHIFT: begin
          w_stateNext = MODE_PINGPONG;
          w_ledNext   = 8'h01;
        end
        MODE_PINGPONG: begin
          w_stateNext = MODE_COUNT;
          w_ledNext   = 8'h00;
        end
        default: begin
          w_stateNext = MODE_BLINK;
          w_ledNext   = 8'h00;
        end
      endcase
    end else if (w_prescTerm) begin
      case (r_state)
        MODE_BLINK: w_ledNext = ~r_led;
        MODE_SHIFT: w_ledNext = {r_led[6:0], r_led[7]};
        MODE_PINGPONG: begin
          w_ledNext = r_dirRight ? {1'b0, r_led[7:1]} : {r_led[6:0], 1'b0};
          if (w_ledNext == 8'h80) begin
            w_dirNext = 1'b1;
          end else if (w_ledNext == 8'h01) begin
            w_dirNext = 1'b0;
          end
        end
        default: w_ledNext = r_led + 8'd1;
      endcase
    end
  end

  assign led       = r_led;
  assign mode      = r_state;
  assign step_tick = w_prescTerm & ~w_press;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl with STEP_DIV=5, DEBOUNCE_CYCLES=4: a cycle model
// queues expected led/mode/step_tick per edge, and each scenario task pops and compares.
module tb_led_mode_ctrl;

  localparam int STEP_DIV        = 5;
  localparam int DEBOUNCE_CYCLES = 4;

  logic       clk;
  logic       rst;
  logic       push_button;
  logic [7:0] led;
  logic [1:0] mode;
  logic       step_tick;

  led_mode_ctrl #(
    .STEP_DIV        (STEP_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_button (push_button),
    .led         (led),
    .mode        (mode),
    .step_tick   (step_tick)
  );

  typedef struct {
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;
  } exp_t;

  exp_t       sb[$];
  int         nChecks = 0;
  int         nFails  = 0;
  int         curEdge;
  int         gPressEdge;
  int         mEdge;
  int         mPresc;
  logic [7:0] mLed;
  logic [1:0] mMode;
  logic       mDirRight;

  // Free-running clock with posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound so a wedged run still ends with a visible failure.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion before 1000000");
    $fatal(1, "[TB] watchdog");
  end

  // Model of the state right after reset release; edge numbering restarts at 0.
  task automatic modelReset();
    mEdge      = 0;
    curEdge    = 0;
    mPresc     = 0;
    mLed       = 8'h00;
    mMode      = 2'd0;
    mDirRight  = 1'b0;
    gPressEdge = -1;
    sb.delete();
  endtask

  // Advances the behavioural model n edges, queueing what should be seen after each one.
  task automatic modelPush(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      mEdge++;
      if (mEdge == gPressEdge) begin
        mMode     = mMode + 2'd1;
        mPresc    = 0;
        mDirRight = 1'b0;
        mLed      = (mMode == 2'd1 || mMode == 2'd2) ? 8'h01 : 8'h00;
      end else if (mPresc == STEP_DIV - 1) begin
        mPresc = 0;
        case (mMode)
          2'd0: mLed = ~mLed;
          2'd1: mLed = {mLed[6:0], mLed[7]};
          2'd2: begin
            if (mDirRight) mLed = mLed >> 1;
            else           mLed = mLed << 1;
            if (mLed == 8'h80)      mDirRight = 1'b1;
            else if (mLed == 8'h01) mDirRight = 1'b0;
          end
          default: mLed = mLed + 8'd1;
        endcase
      end else begin
        mPresc++;
      end
      e.led  = mLed;
      e.mode = mMode;
      e.tick = (mPresc == STEP_DIV - 1) && (mEdge + 1 != gPressEdge);
      sb.push_back(e);
    end
  endtask

  // Moves the design along without checking, used only to reach a starting condition.
  task automatic runFree(input int n, input int relIter);
    exp_t e;
    modelPush(n);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      curEdge++;
      if (i == relIter) push_button = 1'b0;
      e = sb.pop_front();
    end
  endtask

  task automatic pressOnly(input int n);
    push_button = 1'b1;
    gPressEdge  = curEdge + 7;
    runFree(n, 10);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    push_button = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (led !== 8'h00 || mode !== 2'd0 || step_tick !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_state: got led=%h mode=%0d tick=%b, want 00/0/0", led, mode, step_tick);
    end
    rst = 1'b1;
    modelReset();
    modelPush(12);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      curEdge++;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL reset_blink edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
      if (i == 4 || i == 5 || i == 10) begin
        nChecks++;
        if (led !== ((i == 5) ? 8'hFF : 8'h00)) begin
          nFails++;
          $display("[TB] FAIL reset_blink_const edge=%0d: got led=%h, want %h", i, led, (i == 5) ? 8'hFF : 8'h00);
        end
      end
    end
  endtask

  task automatic test_debounce();
    exp_t e;
    push_button = 1'b1;
    modelPush(12);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      curEdge++;
      if (i == 3) push_button = 1'b0;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL glitch edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
    end
    nChecks++;
    if (mode !== 2'd0) begin
      nFails++;
      $display("[TB] FAIL glitch_mode: got mode=%0d, want 0", mode);
    end
    push_button = 1'b1;
    gPressEdge  = curEdge + 7;
    modelPush(10);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      curEdge++;
      if (i == 10) push_button = 1'b0;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL press edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
      if (i == 6) begin
        nChecks++;
        if (mode !== 2'd0) begin
          nFails++;
          $display("[TB] FAIL press_early: got mode=%0d one edge before latency, want 0", mode);
        end
      end
      if (i == 7) begin
        nChecks++;
        if (mode !== 2'd1 || led !== 8'h01) begin
          nFails++;
          $display("[TB] FAIL press_latency: got mode=%0d led=%h at k+6, want 1/01", mode, led);
        end
      end
    end
  endtask

  task automatic test_shift();
    exp_t       e;
    logic [7:0] seq[$];
    logic [7:0] ref8[9];
    logic       prevTick;
    ref8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    prevTick = 1'b0;
    seq.push_back(led);
    modelPush(40);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      curEdge++;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL shift edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
      if (prevTick) seq.push_back(led);
      prevTick = e.tick;
    end
    for (int i = 0; i < 9 && i < seq.size(); i++) begin
      nChecks++;
      if (seq[i] !== ref8[i]) begin
        nFails++;
        $display("[TB] FAIL shift_seq[%0d]: got %h, want %h", i, seq[i], ref8[i]);
      end
    end
  endtask

  task automatic test_pingpong();
    exp_t       e;
    logic [7:0] seq[$];
    logic [7:0] ref16[16];
    logic       prevTick;
    ref16 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    prevTick    = 1'b0;
    push_button = 1'b1;
    gPressEdge  = curEdge + 7;
    modelPush(90);
    for (int i = 1; i <= 90; i++) begin
      @(posedge clk); #1;
      curEdge++;
      if (i == 10) push_button = 1'b0;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL pingpong edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
      if (curEdge >= gPressEdge) begin
        nChecks++;
        if (!$onehot(led)) begin
          nFails++;
          $display("[TB] FAIL pingpong_onehot edge=%0d: got led=%h, want exactly one bit set", curEdge, led);
        end
        if (curEdge == gPressEdge || prevTick) seq.push_back(led);
      end
      prevTick = e.tick;
    end
    for (int i = 0; i < 16 && i < seq.size(); i++) begin
      nChecks++;
      if (seq[i] !== ref16[i]) begin
        nFails++;
        $display("[TB] FAIL pingpong_seq[%0d]: got %h, want %h", i, seq[i], ref16[i]);
      end
    end
  endtask

  task automatic test_count_wrap();
    exp_t e;
    push_button = 1'b1;
    gPressEdge  = curEdge + 7;
    modelPush(1290);
    for (int i = 1; i <= 1290; i++) begin
      @(posedge clk); #1;
      curEdge++;
      if (i == 10) push_button = 1'b0;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL count edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
      if (curEdge == gPressEdge + 1275) begin
        nChecks++;
        if (led !== 8'hFF || mode !== 2'd3) begin
          nFails++;
          $display("[TB] FAIL count_preload: got led=%h mode=%0d after 255 ticks, want FF/3", led, mode);
        end
      end
      if (curEdge == gPressEdge + 1280) begin
        nChecks++;
        if (led !== 8'h00) begin
          nFails++;
          $display("[TB] FAIL count_wrap: got led=%h after 256 ticks, want 00", led);
        end
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    for (int g = 0; g < 10 && mPresc != 3; g++) begin
      modelPush(1);
      @(posedge clk); #1;
      curEdge++;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL collision_align edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
    end
    if (mPresc != 3) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL collision_bound: got prescaler phase %0d after 10 cycles, want 3", mPresc);
    end
    push_button = 1'b1;
    gPressEdge  = curEdge + 7;
    modelPush(16);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      curEdge++;
      if (i == 10) push_button = 1'b0;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL collision edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
      if (i == 6) begin
        nChecks++;
        if (step_tick !== 1'b0 || mode !== 2'd3) begin
          nFails++;
          $display("[TB] FAIL collision_tick: got tick=%b mode=%0d in press cycle, want 0/3", step_tick, mode);
        end
      end
      if (i == 7) begin
        nChecks++;
        if (mode !== 2'd0 || led !== 8'h00) begin
          nFails++;
          $display("[TB] FAIL collision_mode: got mode=%0d led=%h, want 0/00", mode, led);
        end
      end
      if (i == 10 || i == 11) begin
        nChecks++;
        if (step_tick !== (i == 11)) begin
          nFails++;
          $display("[TB] FAIL collision_restart edge=%0d: got tick=%b, want %b", i, step_tick, i == 11);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    pressOnly(30);
    pressOnly(30);
    pressOnly(22);
    nChecks++;
    if (led !== 8'h03 || mode !== 2'd3) begin
      nFails++;
      $display("[TB] FAIL midrun_setup: got led=%h mode=%0d, want 03/3", led, mode);
    end
    #3 rst = 1'b0;
    #1;
    nChecks++;
    if (led !== 8'h00 || mode !== 2'd0 || step_tick !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midrun_async_reset: got led=%h mode=%0d tick=%b, want 00/0/0", led, mode, step_tick);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    modelReset();
    modelPush(12);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      curEdge++;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL midrun_restart edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
    end
  endtask

  task automatic test_held_through_reset();
    exp_t e;
    push_button = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    modelReset();
    gPressEdge = 7;
    modelPush(12);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      curEdge++;
      if (i == 10) push_button = 1'b0;
      e = sb.pop_front();
      nChecks++;
      if (led !== e.led || mode !== e.mode || step_tick !== e.tick) begin
        nFails++;
        $display("[TB] FAIL held_reset edge=%0d: got led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 curEdge, led, mode, step_tick, e.led, e.mode, e.tick);
      end
      if (i == 7) begin
        nChecks++;
        if (mode !== 2'd1 || led !== 8'h01) begin
          nFails++;
          $display("[TB] FAIL held_reset_press: got mode=%0d led=%h at edge 7, want 1/01", mode, led);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    push_button = 1'b0;
    test_reset();
    test_debounce();
    test_shift();
    test_pingpong();
    test_count_wrap();
    test_collision();
    test_reset_midrun();
    test_held_through_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
